// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S audio transmit path.
package audio_pkg;

  localparam int unsigned I2S_SLOT_BITS = 16;

  typedef struct packed {
    logic signed [I2S_SLOT_BITS-1:0] left;
    logic signed [I2S_SLOT_BITS-1:0] right;
  } stereo_sample_t;

  typedef enum logic [1:0] {
    GEN_HALT,
    GEN_START,
    GEN_RUN
  } gen_state_t;

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Stereo sample handshake between the mixer (master) and the I2S transmitter (slave).
interface audio_i2s_tx_if
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH = I2S_SLOT_BITS
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_left;
  logic signed [WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);

endinterface

// File: rtl/audio_bclk_gen.sv
// BCLK divider with a fall-event strobe; halts at a frame boundary on request.
module audio_bclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic stop,
  output logic bclk,
  output logic fall,
  output logic first
);

  localparam int unsigned DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  gen_state_t    state, state_next;
  logic [DW-1:0] div_cnt;
  logic          running;
  logic          wrap;

  assign running = (state != GEN_HALT);
  assign wrap    = running && (div_cnt == DW'(BCLK_DIV - 1));
  assign fall    = wrap && bclk;
  // first marks the pending fall event after a (re)start, which opens a new frame
  assign first   = (state == GEN_START);

  always_comb begin
    state_next = state;
    unique case (state)
      GEN_HALT:  if (enable) state_next = GEN_START;
      GEN_START: if (fall) state_next = stop ? GEN_HALT : GEN_RUN;
      GEN_RUN:   if (fall && stop) state_next = GEN_HALT;
      default:   state_next = GEN_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= GEN_HALT;
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else begin
      state <= state_next;
      if (!running) begin
        div_cnt <= '0;
        bclk    <= 1'b0;
      end else if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: one-entry holding register, frame loader and one-bit-delayed serializer.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH    = I2S_SLOT_BITS,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  audio_i2s_tx_if.slave  sample_bus,
  output logic           i2s_bclk,
  output logic           i2s_lrck,
  output logic           i2s_sdata,
  output logic           underrun
);

  localparam int unsigned FRAME_BITS = 2 * WIDTH;
  localparam int unsigned BW         = $clog2(FRAME_BITS);

  logic                  fall;
  logic                  first;
  logic                  frame_edge;
  logic                  stop;
  logic                  load;
  logic                  xfer;
  logic                  full;
  logic [BW-1:0]         bit_cnt;
  logic [BW-1:0]         bit_next;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [FRAME_BITS-1:0] hold;
  logic [FRAME_BITS-1:0] last;

  assign frame_edge = first || (bit_cnt == BW'(FRAME_BITS - 1));
  assign stop       = frame_edge && !enable;
  assign load       = fall && frame_edge && enable;
  assign bit_next   = frame_edge ? '0 : bit_cnt + 1'b1;
  assign xfer       = sample_bus.in_valid && !full;

  assign sample_bus.in_ready = !full;

  audio_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .stop    (stop),
    .bclk    (i2s_bclk),
    .fall    (fall),
    .first   (first)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      i2s_lrck  <= 1'b0;
      i2s_sdata <= 1'b0;
      shift_reg <= '0;
      hold      <= '0;
      last      <= '0;
      full      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= load && !full;
      if (fall) begin
        bit_cnt  <= bit_next;
        i2s_lrck <= (bit_next >= BW'(WIDTH));
        // sdata trails the shift MSB by one slot; the stopping edge forces it low
        i2s_sdata <= stop ? 1'b0 : shift_reg[FRAME_BITS-1];
        if (load) shift_reg <= full ? hold : last;
        else      shift_reg <= shift_reg << 1;
      end
      // a load and a transfer never coincide on a full register, so the old contents win
      if (load && full) begin
        last <= hold;
        full <= 1'b0;
      end else if (xfer) begin
        hold <= {sample_bus.in_left, sample_bus.in_right};
        full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx against a frame-level reference model.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  localparam int WIDTH     = I2S_SLOT_BITS;
  localparam int BCLK_DIV  = 2;
  localparam int FRAME     = 2 * WIDTH;
  localparam int FRAME_CLK = FRAME * 2 * BCLK_DIV;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic enable  = 1'b0;
  logic i2s_bclk, i2s_lrck, i2s_sdata, underrun;
  logic [4:0] obs;
  logic [4:0] exp_v;

  int tests = 0;
  int fails = 0;

  // reference model state
  bit             m_run, m_full, m_fell, m_xfer, m_prev_lsb;
  bit             e_bclk, e_lrck, e_sdata, e_urun;
  int             m_cyc, m_slot;
  stereo_sample_t m_hold, m_last, m_frame;

  audio_i2s_tx_if #(.WIDTH(WIDTH)) bus ();

  audio_i2s_tx #(.WIDTH(WIDTH), .BCLK_DIV(BCLK_DIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .sample_bus (bus),
    .i2s_bclk   (i2s_bclk),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  assign obs = {i2s_bclk, i2s_lrck, i2s_sdata, underrun, bus.in_ready};

  task automatic model_reset();
    m_run = 0; m_full = 0; m_fell = 0; m_xfer = 0; m_prev_lsb = 0;
    e_bclk = 0; e_lrck = 0; e_sdata = 0; e_urun = 0;
    m_cyc = 0; m_slot = -1;
    m_hold = '0; m_last = '0; m_frame = '0;
    exp_v = 5'b00001;
  endtask

  // Predicts the effect of the next rising clk edge, then moves to the following falling edge.
  task automatic tick();
    bit old_full;
    int nxt;
    logic [FRAME-1:0] fb;
    old_full = m_full;
    m_xfer   = bus.in_valid && !m_full;
    m_fell   = 0;
    e_urun   = 0;
    if (m_run) begin
      m_cyc++;
      e_bclk = ((m_cyc / BCLK_DIV) % 2) == 1;
      if (m_cyc % (2 * BCLK_DIV) == 0) begin
        m_fell = 1;
        nxt = (m_slot < 0 || m_slot == FRAME - 1) ? 0 : m_slot + 1;
        if (nxt == 0 && !enable) begin
          e_sdata = 0; e_lrck = 0; m_run = 0; m_slot = -1; m_prev_lsb = 0;
        end else begin
          e_lrck = (nxt >= WIDTH);
          if (nxt == 0) begin
            e_sdata = m_prev_lsb;
            if (old_full) begin
              m_frame = m_hold; m_last = m_hold; m_full = 0;
            end else begin
              m_frame = m_last; e_urun = 1;
            end
            fb = m_frame;
            m_prev_lsb = fb[0];
          end else begin
            fb = m_frame;
            e_sdata = fb[FRAME - nxt];
          end
          m_slot = nxt;
        end
      end
    end else if (enable) begin
      m_run = 1;
      m_cyc = 0;
    end
    if (m_xfer) begin
      m_full = 1;
      m_hold.left  = bus.in_left;
      m_hold.right = bus.in_right;
    end
    exp_v = {e_bclk, e_lrck, e_sdata, e_urun, !m_full};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic seek_slot(input int slot, output bit ok);
    ok = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !ok; i++) begin
      tick();
      if (m_fell && m_slot == slot) ok = 1;
    end
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 0;
    bus.in_valid = 0; bus.in_left = '0; bus.in_right = '0;
    repeat (3) @(negedge clk);
    tests++; if (i2s_bclk !== 1'b0)  begin fails++; $display("FAIL reset_bclk got=%b required=0", i2s_bclk); end
    tests++; if (i2s_lrck !== 1'b0)  begin fails++; $display("FAIL reset_lrck got=%b required=0", i2s_lrck); end
    tests++; if (i2s_sdata !== 1'b0) begin fails++; $display("FAIL reset_sdata got=%b required=0", i2s_sdata); end
    tests++; if (underrun !== 1'b0)  begin fails++; $display("FAIL reset_underrun got=%b required=0", underrun); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b required=1", bus.in_ready); end
    reset_n = 1;
    model_reset();
  endtask

  task automatic test_basic_frame();
    logic [FRAME-1:0] cap;
    int starts, urun;
    cap = '0; starts = 0; urun = 0;
    bus.in_left = 16'hA5C3; bus.in_right = 16'h8001; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL basic_ready_low got=%b required=0", bus.in_ready); end
    enable = 1;
    for (int i = 0; i < 4 * FRAME_CLK && starts < 2; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL basic_cycle t=%0t got(bclk,lrck,sdata,urun,rdy)=%b required=%b", $time, obs, exp_v); end
      if (underrun === 1'b1) urun++;
      if (m_fell) begin
        if (m_slot == 0) begin
          if (starts == 1) cap[0] = i2s_sdata;
          starts++;
        end else if (starts == 1) begin
          cap[FRAME - m_slot] = i2s_sdata;
        end
      end
    end
    tests++; if (starts != 2) begin fails++; $display("FAIL basic_timeout got=%0d frame starts required=2", starts); end
    tests++; if (cap !== 32'hA5C38001) begin fails++; $display("FAIL basic_word got=%h required=a5c38001", cap); end
    tests++; if (urun != 1) begin fails++; $display("FAIL basic_underrun got=%0d required=1", urun); end
  endtask

  task automatic test_underrun();
    int urun;
    urun = 0;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL underrun_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (underrun === 1'b1) urun++;
    end
    tests++; if (urun != 2) begin fails++; $display("FAIL underrun_count got=%0d required=2", urun); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] base;
    int acc;
    acc = 0;
    base = 16'($urandom);
    bus.in_left = base; bus.in_right = ~base; bus.in_valid = 1;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      if (bus.in_ready === 1'b1) acc++;
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL backpressure_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (m_xfer) begin
        base = base + 1'b1;
        bus.in_left = base; bus.in_right = ~base;
      end
    end
    bus.in_valid = 0;
    tests++; if (acc != 4) begin fails++; $display("FAIL backpressure_accepts got=%0d required=4", acc); end
  endtask

  task automatic test_collision();
    bit found;
    int urun;
    stereo_sample_t p;
    found = 0; urun = 0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      if (m_run && m_slot == FRAME - 1 && ((m_cyc + 1) % (2 * BCLK_DIV)) == 0) found = 1;
      else tick();
    end
    tests++; if (!found) begin fails++; $display("FAIL collision_timeout got=0 required=1"); end
    p = stereo_sample_t'($urandom);
    bus.in_left = p.left; bus.in_right = p.right; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL collision_underrun got=%b required=1", underrun); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL collision_ready got=%b required=0", bus.in_ready); end
    for (int i = 0; i < FRAME_CLK; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL collision_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (underrun === 1'b1) urun++;
    end
    tests++; if (urun != 0) begin fails++; $display("FAIL collision_next_frame got=%0d underruns required=0", urun); end
  endtask

  task automatic test_enable_stop();
    bit ok;
    int urun;
    stereo_sample_t p;
    urun = 0;
    seek_slot(10, ok);
    tests++; if (!ok) begin fails++; $display("FAIL stop_seek got=0 required=1"); end
    enable = 0;
    p = stereo_sample_t'($urandom);
    bus.in_left = p.left; bus.in_right = p.right; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL stop_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
    end
    tests++; if ({i2s_bclk, i2s_lrck, i2s_sdata} !== 3'b000) begin fails++; $display("FAIL stop_idle got=%b required=000", {i2s_bclk, i2s_lrck, i2s_sdata}); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stop_hold_kept got=%b required=0", bus.in_ready); end
    enable = 1;
    for (int i = 0; i < FRAME_CLK; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL restart_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (underrun === 1'b1) urun++;
    end
    tests++; if (urun != 0) begin fails++; $display("FAIL restart_underrun got=%0d required=0", urun); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int urun;
    stereo_sample_t p;
    urun = 0;
    p = stereo_sample_t'($urandom);
    bus.in_left = p.left; bus.in_right = p.right; bus.in_valid = 1;
    tick();
    bus.in_valid = 0;
    seek_slot(20, ok);
    tests++; if (!ok) begin fails++; $display("FAIL areset_seek got=0 required=1"); end
    #2 reset_n = 0;
    #1;
    tests++; if ({i2s_bclk, i2s_lrck, i2s_sdata, underrun} !== 4'b0000) begin fails++; $display("FAIL areset_outputs got=%b required=0000", {i2s_bclk, i2s_lrck, i2s_sdata, underrun}); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL areset_ready got=%b required=1", bus.in_ready); end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < FRAME_CLK; i++) begin
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL areset_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (underrun === 1'b1) urun++;
    end
    tests++; if (urun != 1) begin fails++; $display("FAIL areset_underrun got=%0d required=1", urun); end
  endtask

  task automatic test_random();
    stereo_sample_t p;
    p = stereo_sample_t'($urandom);
    bus.in_left = p.left; bus.in_right = p.right; bus.in_valid = 0;
    for (int i = 0; i < 6 * FRAME_CLK; i++) begin
      if (!bus.in_valid && $urandom_range(0, 3) == 0) bus.in_valid = 1;
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      tick();
      tests++; if (obs !== exp_v) begin fails++; $display("FAIL random_cycle t=%0t got=%b required=%b", $time, obs, exp_v); end
      if (m_xfer) begin
        p = stereo_sample_t'($urandom);
        bus.in_left = p.left; bus.in_right = p.right; bus.in_valid = 0;
      end
    end
    enable = 1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_frame();
    test_underrun();
    test_backpressure();
    test_collision();
    test_enable_stop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
